// File: rtl/fifo_serializer.sv
// fifo_serializer
//   Pulls full-width words from a fifo_1r1w read port (valid/data/yumi) and
//   emits them as narrower chunks on a valid/ready stream, LSB chunk first.
//   It sustains one chunk per cycle with no bubble between consecutive words.
//
// Parameters
//   width_p  input word width (must match the upstream FIFO width)
//   chunk_p  output chunk width (width_p must be a multiple, ratio >= 2)
//
// Ports
//   clk_i    clock, all state updates on posedge
//   reset_i  synchronous active-high reset
//   valid_i  upstream word available (FIFO valid_o)
//   data_i   upstream word (FIFO data_o)
//   yumi_o   word consumed this cycle (FIFO yumi_i)
//   valid_o  chunk available on data_o
//   data_o   current chunk
//   last_o   current chunk is the final chunk of its word
//   ready_i  downstream accepts the chunk this cycle
module fifo_serializer #(
  parameter int width_p = 32,
  parameter int chunk_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               valid_o,
  output logic [chunk_p-1:0] data_o,
  output logic               last_o,
  input  logic               ready_i
);

  localparam int num_chunks_p = width_p / chunk_p;
  localparam int cnt_w        = $clog2(num_chunks_p);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_chunks_p - 1);

  if ((num_chunks_p < 2) || ((width_p % chunk_p) != 0)) begin : g_bad_params
    $error("fifo_serializer: width_p must be a multiple of chunk_p with at least two chunks");
  end

  typedef enum logic {EMPTY, SEND} state_e;

  state_e             state_r, state_n;
  logic [width_p-1:0] shift_r;
  logic [cnt_w-1:0]   cnt_r;
  logic               xfer;     // downstream transfer this cycle
  logic               is_last;  // counter sits on the final chunk

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= EMPTY;
    else         state_r <= state_n;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      EMPTY: if (valid_i) state_n = SEND;
      SEND:  if (xfer && is_last && !valid_i) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  assign is_last = (cnt_r == last_cnt);

  always_comb begin
    valid_o = (state_r == SEND);
    last_o  = valid_o & is_last;
    data_o  = shift_r[chunk_p-1:0];
    xfer    = valid_o & ready_i;
    // Reset gating keeps the FIFO from losing a word while we are held in reset.
    yumi_o  = valid_i & ~reset_i & ((state_r == EMPTY) | (xfer & last_o));
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register and chunk counter
  // ---------------------------------------------------------------------------
  // NOTE: shift_r is reset (not left uninitialised like a storage array)
  // because data_o is read straight from it and must be 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (yumi_o) begin
      // Covers both the EMPTY load and the no-bubble reload on the last chunk.
      shift_r <= data_i;
      cnt_r   <= '0;
    end else if (xfer) begin
      shift_r <= shift_r >> chunk_p;
      // The last chunk always wraps to 0, so non-power-of-2 ratios never
      // leave the counter past num_chunks_p-1.
      cnt_r   <= is_last ? '0 : cnt_r + cnt_w'(1);
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer
//   Table-driven checks of fifo_serializer: a 32/8 instance for single word,
//   back-to-back, backpressure, last-chunk stall and mid-word reset, and a
//   24/8 instance for the non-power-of-2 chunk ratio.
module tb_fifo_serializer;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] d;
    logic        rdy;
    logic        e_yumi;
    logic        e_vld;
    logic        e_last;
    logic [7:0]  e_d;
    logic        chk_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_valid_i = 1'b0, a_ready_i = 1'b0;
  logic [31:0] a_data_i = '0;
  logic        a_yumi, a_valid_o, a_last;
  logic [7:0]  a_data_o;

  logic        b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic [23:0] b_data_i = '0;
  logic        b_yumi, b_valid_o, b_last;
  logic [7:0]  b_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_serializer #(.width_p(32), .chunk_p(8)) dut_a (
    .clk_i(clk), .reset_i(reset),
    .valid_i(a_valid_i), .data_i(a_data_i), .yumi_o(a_yumi),
    .valid_o(a_valid_o), .data_o(a_data_o), .last_o(a_last), .ready_i(a_ready_i)
  );

  fifo_serializer #(.width_p(24), .chunk_p(8)) dut_b (
    .clk_i(clk), .reset_i(reset),
    .valid_i(b_valid_i), .data_i(b_data_i), .yumi_o(b_yumi),
    .valid_o(b_valid_o), .data_o(b_data_o), .last_o(b_last), .ready_i(b_ready_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic vld, input logic [31:0] d,
                              input logic rdy, input logic e_yumi, input logic e_vld,
                              input logic e_last, input logic [7:0] e_d, input logic chk_d);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d = d; v.rdy = rdy;
    v.e_yumi = e_yumi; v.e_vld = e_vld; v.e_last = e_last; v.e_d = e_d; v.chk_d = chk_d;
    return v;
  endfunction

  // One cycle: drive just after posedge, compare mid-cycle.
  task automatic run_vec(input vec_t v, input bit use_b, input string tag);
    @(posedge clk);
    #1;
    reset = v.rst;
    if (use_b) begin
      b_valid_i = v.vld; b_data_i = v.d[23:0]; b_ready_i = v.rdy;
    end else begin
      a_valid_i = v.vld; a_data_i = v.d; a_ready_i = v.rdy;
    end
    #4;
    if (use_b) begin
      check({tag, " yumi"},  {31'b0, b_yumi},    {31'b0, v.e_yumi});
      check({tag, " valid"}, {31'b0, b_valid_o}, {31'b0, v.e_vld});
      check({tag, " last"},  {31'b0, b_last},    {31'b0, v.e_last});
      if (v.chk_d) check({tag, " data"}, {24'b0, b_data_o}, {24'b0, v.e_d});
    end else begin
      check({tag, " yumi"},  {31'b0, a_yumi},    {31'b0, v.e_yumi});
      check({tag, " valid"}, {31'b0, a_valid_o}, {31'b0, v.e_vld});
      check({tag, " last"},  {31'b0, a_last},    {31'b0, v.e_last});
      if (v.chk_d) check({tag, " data"}, {24'b0, a_data_o}, {24'b0, v.e_d});
    end
  endtask

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  initial begin
    //                   rst vld data          rdy yumi vld last data chk
    // Reset state, with valid_i=1 to show yumi is gated during reset
    tbl_a.push_back(mk(1, 1, 32'h0BAD0BAD, 1, 0, 0, 0, 8'h00, 1));
    // Single word DDCCBBAA
    tbl_a.push_back(mk(0, 1, 32'hDDCCBBAA, 1, 1, 0, 0, 8'h00, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hAA, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hBB, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hCC, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 1, 8'hDD, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 0, 0, 8'h00, 0));
    // Back-to-back 44332211 then 88776655, no gap
    tbl_a.push_back(mk(0, 1, 32'h44332211, 1, 1, 0, 0, 8'h00, 0));
    tbl_a.push_back(mk(0, 1, 32'h88776655, 1, 0, 1, 0, 8'h11, 1));
    tbl_a.push_back(mk(0, 1, 32'h88776655, 1, 0, 1, 0, 8'h22, 1));
    tbl_a.push_back(mk(0, 1, 32'h88776655, 1, 0, 1, 0, 8'h33, 1));
    tbl_a.push_back(mk(0, 1, 32'h88776655, 1, 1, 1, 1, 8'h44, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'h55, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'h66, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'h77, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 1, 8'h88, 1));
    // Backpressure on BB, next word waiting upstream
    tbl_a.push_back(mk(0, 1, 32'hDDCCBBAA, 1, 1, 0, 0, 8'h00, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hAA, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 0, 0, 1, 0, 8'hBB, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 0, 0, 1, 0, 8'hBB, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 0, 0, 1, 0, 8'hBB, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 1, 0, 1, 0, 8'hBB, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 1, 0, 1, 0, 8'hCC, 1));
    // Last-chunk stall with valid_i=1, then release
    tbl_a.push_back(mk(0, 1, 32'h12345678, 0, 0, 1, 1, 8'hDD, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 0, 0, 1, 1, 8'hDD, 1));
    tbl_a.push_back(mk(0, 1, 32'h12345678, 1, 1, 1, 1, 8'hDD, 1));
    // Reset after chunk 78 transfers
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'h78, 1));
    tbl_a.push_back(mk(1, 1, 32'h0BAD0BAD, 1, 0, 1, 0, 8'h56, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 0, 0, 8'h00, 1));
    // New word after reset starts from its chunk 0
    tbl_a.push_back(mk(0, 1, 32'hA1B2C3D4, 1, 1, 0, 0, 8'h00, 0));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hD4, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hC3, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 0, 8'hB2, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 1, 1, 8'hA1, 1));
    tbl_a.push_back(mk(0, 0, 32'h0,        1, 0, 0, 0, 8'h00, 0));

    // 24/8 instance: CCBBAA then 332211 back to back
    tbl_b.push_back(mk(0, 1, 32'hCCBBAA, 1, 1, 0, 0, 8'h00, 0));
    tbl_b.push_back(mk(0, 1, 32'h332211, 1, 0, 1, 0, 8'hAA, 1));
    tbl_b.push_back(mk(0, 1, 32'h332211, 1, 0, 1, 0, 8'hBB, 1));
    tbl_b.push_back(mk(0, 1, 32'h332211, 1, 1, 1, 1, 8'hCC, 1));
    tbl_b.push_back(mk(0, 0, 32'h0,      1, 0, 1, 0, 8'h11, 1));
    tbl_b.push_back(mk(0, 0, 32'h0,      1, 0, 1, 0, 8'h22, 1));
    tbl_b.push_back(mk(0, 0, 32'h0,      1, 0, 1, 1, 8'h33, 1));
    tbl_b.push_back(mk(0, 0, 32'h0,      1, 0, 0, 0, 8'h00, 0));

    // Hold reset over two edges before the tables start.
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl_a.size(); i++)
      run_vec(tbl_a[i], 1'b0, $sformatf("a%0d", i));

    // Reset state of the 24-bit instance after the whole run idling.
    #1;
    check("b idle valid", {31'b0, b_valid_o}, 32'd0);
    check("b idle last",  {31'b0, b_last},    32'd0);

    for (int i = 0; i < tbl_b.size(); i++)
      run_vec(tbl_b[i], 1'b1, $sformatf("b%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
